// File: rtl/master_cmd_pkg.sv
// Shared types for the master command queue: record layout, staging word map,
// controller state codes and the staging word-merge helper.
package master_cmd_pkg;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] dfreq;
    logic [31:0] drate;
    logic [47:0] tstart;
    logic [15:0] n_impuls;
    logic [1:0]  cmd_type;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_rec_t;

  localparam logic [3:0] W_FREQ_LO   = 4'd0;
  localparam logic [3:0] W_FREQ_HI   = 4'd1;
  localparam logic [3:0] W_DFREQ_LO  = 4'd2;
  localparam logic [3:0] W_DFREQ_HI  = 4'd3;
  localparam logic [3:0] W_DRATE     = 4'd4;
  localparam logic [3:0] W_TSTART_LO = 4'd5;
  localparam logic [3:0] W_TSTART_HI = 4'd6;
  localparam logic [3:0] W_TYPE_N    = 4'd7;
  localparam logic [3:0] W_TI        = 4'd8;
  localparam logic [3:0] W_TP        = 4'd9;
  localparam logic [3:0] W_TBLANK1   = 4'd10;
  localparam logic [3:0] W_TBLANK2   = 4'd11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  // Indices 12..15 leave the record untouched.
  function automatic cmd_rec_t put_word(input cmd_rec_t r, input logic [3:0] idx,
                                        input logic [31:0] d);
    cmd_rec_t n;
    n = r;
    case (idx)
      W_FREQ_LO:   n.freq[31:0]   = d;
      W_FREQ_HI:   n.freq[47:32]  = d[15:0];
      W_DFREQ_LO:  n.dfreq[31:0]  = d;
      W_DFREQ_HI:  n.dfreq[47:32] = d[15:0];
      W_DRATE:     n.drate        = d;
      W_TSTART_LO: n.tstart[31:0] = d;
      W_TSTART_HI: n.tstart[47:32] = d[15:0];
      W_TYPE_N: begin
        n.cmd_type = d[17:16];
        n.n_impuls = d[15:0];
      end
      W_TI:        n.ti      = d;
      W_TP:        n.tp      = d;
      W_TBLANK1:   n.tblank1 = d;
      W_TBLANK2:   n.tblank2 = d;
      default:     n = r;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cmd_rec_fifo.sv
// DEPTH-deep circular buffer of command records with push, pop, flush and level.
module cmd_rec_fifo
  import master_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  cmd_rec_t    din,
  output cmd_rec_t    dout,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  cmd_rec_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/master_cmd_queue.sv
// Command record queue feeding MASTER_START. Define MASTER_CMD_LATE_DROP_EN to
// drop records whose start time has already passed when they reach the head.
module master_cmd_queue
  import master_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_WORD,
  input  logic [3:0]  WR_ADDR,
  input  logic [31:0] WR_DAT,
  input  logic        COMMIT,
  input  logic        FLUSH,
  input  logic        CMD_DONE,
  input  logic [47:0] TIME_NOW,
  output logic        WR_DATA,
  output logic [47:0] MEM_DDS_freq,
  output logic [47:0] MEM_DDS_delta_freq,
  output logic [31:0] MEM_DDS_delta_rate,
  output logic [47:0] MEM_TIME_START,
  output logic [15:0] MEM_N_impuls,
  output logic [1:0]  MEM_TYPE_impulse,
  output logic [31:0] MEM_Interval_Ti,
  output logic [31:0] MEM_Interval_Tp,
  output logic [31:0] MEM_Tblank1,
  output logic [31:0] MEM_Tblank2,
  output logic [AW:0] Q_LEVEL,
  output logic        Q_FULL,
  output logic        Q_EMPTY,
  output logic        OVF,
  output logic        LATE
);

  logic [1:0] state;
  logic       armed;
  logic       late_q;
  logic       late_hit;
  logic       pop;
  cmd_rec_t   stage;
  cmd_rec_t   stage_nxt;
  cmd_rec_t   head;
  cmd_rec_t   mem_q;

  // The word written this cycle is merged before a same-cycle COMMIT samples it.
  assign stage_nxt = WR_WORD ? put_word(stage, WR_ADDR, WR_DAT) : stage;
  assign pop       = (state == FETCH) && !FLUSH;

  cmd_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (COMMIT),
    .pop   (pop),
    .flush (FLUSH),
    .din   (stage_nxt),
    .dout  (head),
    .level (Q_LEVEL),
    .full  (Q_FULL),
    .empty (Q_EMPTY)
  );

`ifdef MASTER_CMD_LATE_DROP_EN
  assign late_hit = (head.tstart <= TIME_NOW);
`else
  logic unused_time;
  assign late_hit    = 1'b0;
  assign unused_time = ^TIME_NOW;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      armed  <= 1'b1;
      stage  <= '0;
      mem_q  <= '0;
      OVF    <= 1'b0;
      late_q <= 1'b0;
    end else begin
      stage <= stage_nxt;
      if (COMMIT && !FLUSH && Q_FULL) OVF <= 1'b1;
      if (FLUSH) begin
        state <= IDLE;
        armed <= 1'b1;
      end else begin
        case (state)
          IDLE: if (armed && !Q_EMPTY) state <= FETCH;
          FETCH: begin
            if (late_hit) begin
              late_q <= 1'b1;
              state  <= IDLE;
            end else begin
              mem_q <= head;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            armed <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
        // Placed after the ISSUE clear so a coinciding CMD_DONE leaves ARMED set.
        if (CMD_DONE) armed <= 1'b1;
      end
    end
  end

  assign WR_DATA            = (state == ISSUE) && !FLUSH && !RESET;
  assign LATE               = late_q;
  assign MEM_DDS_freq       = mem_q.freq;
  assign MEM_DDS_delta_freq = mem_q.dfreq;
  assign MEM_DDS_delta_rate = mem_q.drate;
  assign MEM_TIME_START     = mem_q.tstart;
  assign MEM_N_impuls       = mem_q.n_impuls;
  assign MEM_TYPE_impulse   = mem_q.cmd_type;
  assign MEM_Interval_Ti    = mem_q.ti;
  assign MEM_Interval_Tp    = mem_q.tp;
  assign MEM_Tblank1        = mem_q.tblank1;
  assign MEM_Tblank2        = mem_q.tblank2;

endmodule
